// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM responder: word-addressed memory behind a pipelined address/data phase,
// programmable wait states, byte/halfword/word writes and the two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]            wait_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            lane_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic       accepting;
  logic       capture;
  logic       illegal;
  logic [3:0] byte_en;
  logic       unused_inputs;

  assign unused_inputs = ^{hburst, hprot};

  // A new address phase may only be taken when no data phase is stalling the bus.
  assign accepting = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
  assign capture   = accepting && hsel && hready && htrans[1];

  assign illegal = (hsize > 3'b010)
                || ((hsize == 3'b001) && haddr[0])
                || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                || (haddr >= MEM_BYTES);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_WAIT:  state_next = (wait_cnt == 4'd0) ? S_DONE : S_WAIT;
      S_ERR1:  state_next = S_ERR2;
      default: begin
        if (capture) begin
          if (illegal)               state_next = S_ERR1;
          else if (WAIT_STATES == 0) state_next = S_DONE;
          else                       state_next = S_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 2'b00;
    hrdata    = '0;
    case (state)
      S_WAIT: hreadyout = 1'b0;
      S_DONE: hrdata    = mem[idx_q];
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
      end
      S_ERR2: hresp = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      lane_q   <= 2'b00;
      write_q  <= 1'b0;
      size_q   <= 3'b000;
    end else if (capture) begin
      wait_cnt <= WAIT_LOAD;
      idx_q    <= haddr[IDX_W+1:2];
      lane_q   <= haddr[1:0];
      write_q  <= hwrite;
      size_q   <= hsize;
    end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Little-endian lane selection from the latched size and low address bits.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'b000:  byte_en = 4'b0001 << lane_q;
      3'b001:  byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      3'b010:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Writes land on the edge that ends DONE, so a following read phase sees them.
  always_ff @(posedge hclk) begin
    if (!hreset && (state == S_DONE) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule
